// File: rtl/instr_mem_banked.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_banked
//  Description : Loadable, multi-slot instruction memory for the MIPS
//                datapath. Programs are streamed in through a valid/ready
//                load port; the fetch port reads the selected slot with one
//                cycle of registered latency and returns NOP plus a fault
//                flag for out-of-range or unloaded slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_banked #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int PROG_WORDS   = 32,
  parameter int NUM_PROGRAMS = 4,
  parameter int SEL_W        = $clog2(NUM_PROGRAMS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // fetch port
  input  logic [SEL_W-1:0]      prog_sel,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] instrucao,
  output logic                  fetch_fault,
  // load port
  input  logic                  load_start,
  input  logic [SEL_W-1:0]      load_prog,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done
);

  // Storage geometry: slots are laid out back to back in one flat array.
  localparam int c_depth = NUM_PROGRAMS * PROG_WORDS;
  localparam int c_idx_w = (c_depth > 1) ? $clog2(c_depth) : 1;
  localparam int c_cnt_w = $clog2(PROG_WORDS);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(PROG_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Memory array is deliberately left without reset; only the slot flags
  // decide whether its contents are visible to the fetch port.
  logic [DATA_WIDTH-1:0]   r_mem [0:c_depth-1];
  logic [NUM_PROGRAMS-1:0] r_loaded;

  state_t                  r_state;
  logic [SEL_W-1:0]        r_cur_prog;
  logic [c_cnt_w-1:0]      r_cnt;
  logic                    r_load_ready;
  logic                    r_load_busy;
  logic                    r_load_done;

  logic                    r_fetch_valid;
  logic                    r_fetch_fault;
  logic [DATA_WIDTH-1:0]   r_instr;

  logic                    w_sel_in_range;
  logic                    w_addr_in_range;
  logic                    w_fetch_hit;
  logic [c_idx_w-1:0]      w_fetch_idx;
  logic                    w_start_ok;
  logic                    w_load_fire;
  logic [c_idx_w-1:0]      w_load_idx;

  // Fetch qualification: a slot select beyond the slot count behaves as an
  // unloaded slot, so it is screened before the flag lookup.
  assign w_sel_in_range  = (32'(prog_sel) < 32'(NUM_PROGRAMS));
  assign w_addr_in_range = (32'(fetch_addr) < 32'(PROG_WORDS));
  assign w_fetch_hit     = w_sel_in_range && w_addr_in_range && r_loaded[prog_sel];
  assign w_fetch_idx     = c_idx_w'(prog_sel) * c_idx_w'(PROG_WORDS)
                         + c_idx_w'(fetch_addr);

  // Loader qualification: starts naming a non-existent slot are dropped.
  assign w_start_ok  = load_start && (32'(load_prog) < 32'(NUM_PROGRAMS));
  assign w_load_fire = (r_state == S_LOAD) && load_valid;
  assign w_load_idx  = c_idx_w'(r_cur_prog) * c_idx_w'(PROG_WORDS)
                     + c_idx_w'(r_cnt);

  // Loader FSM: owns the slot flags, word counter and load-port outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cur_prog   <= '0;
      r_cnt        <= '0;
      r_loaded     <= '0;
      r_load_ready <= 1'b0;
      r_load_busy  <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            // The flag drops immediately so fetches never see a half-written slot.
            r_state             <= S_LOAD;
            r_cur_prog          <= load_prog;
            r_loaded[load_prog] <= 1'b0;
            r_cnt               <= '0;
            r_load_ready        <= 1'b1;
            r_load_busy         <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            if (r_cnt == c_last) begin
              // Flag is set on the same edge that enters DONE so a fetch
              // issued during DONE already sees the new program.
              r_state              <= S_DONE;
              r_cnt                <= '0;
              r_loaded[r_cur_prog] <= 1'b1;
              r_load_ready         <= 1'b0;
              r_load_done          <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_load_ready <= 1'b0;
          r_load_busy  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_load_ready <= 1'b0;
          r_load_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory write port, fed by accepted load beats; blocked while in reset.
  always_ff @(posedge clock) begin
    if (reset_n && w_load_fire) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

  // Registered fetch port: one-cycle latency, NOP plus fault on a miss,
  // instruction held when no fetch is requested.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_instr       <= '0;
    end else begin
      r_fetch_valid <= fetch_req;
      if (fetch_req) begin
        if (w_fetch_hit) begin
          r_instr       <= r_mem[w_fetch_idx];
          r_fetch_fault <= 1'b0;
        end else begin
          r_instr       <= '0;
          r_fetch_fault <= 1'b1;
        end
      end else begin
        r_fetch_fault <= 1'b0;
      end
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign instrucao   = r_instr;
  assign fetch_fault = r_fetch_fault;
  assign load_ready  = r_load_ready;
  assign load_busy   = r_load_busy;
  assign load_done   = r_load_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_banked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_banked
//  Description : Directed self-checking bench for instr_mem_banked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_banked;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int PW = 32;
  localparam int NP = 4;
  localparam int SW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [SW-1:0] prog_sel;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] instrucao;
  logic          fetch_fault;
  logic          load_start;
  logic [SW-1:0] load_prog;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_busy;
  logic          load_done;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            words;
  logic          acc;
  logic [DW-1:0] e_instr;
  logic          e_fault;
  logic          e_done;

  instr_mem_banked #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .PROG_WORDS  (PW),
    .NUM_PROGRAMS(NP),
    .SEL_W       (SW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .prog_sel   (prog_sel),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_valid(fetch_valid),
    .instrucao  (instrucao),
    .fetch_fault(fetch_fault),
    .load_start (load_start),
    .load_prog  (load_prog),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle past the edge before sampling or driving.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic fetch(input logic [SW-1:0] s, input int a);
    prog_sel   = s;
    fetch_req  = 1'b1;
    fetch_addr = AW'(a);
  endtask

  initial begin
    reset_n    = 1'b0;
    prog_sel   = '0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_prog  = '0;
    load_valid = 1'b0;
    load_data  = '0;
    tick;
    tick;
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_instr",       instrucao,        32'd0);
    chk("rst_fault",       32'(fetch_fault), 32'd0);
    chk("rst_ready",       32'(load_ready),  32'd0);
    chk("rst_busy",        32'(load_busy),   32'd0);
    chk("rst_done",        32'(load_done),   32'd0);

    // Unloaded slot 0 faults with one-cycle latency.
    reset_n = 1'b1;
    fetch(0, 0);
    tick;
    chk("unl_valid", 32'(fetch_valid), 32'd1);
    chk("unl_fault", 32'(fetch_fault), 32'd1);
    chk("unl_instr", instrucao,        32'd0);
    fetch_req = 1'b0;
    tick;
    chk("idle_valid", 32'(fetch_valid), 32'd0);
    chk("idle_fault", 32'(fetch_fault), 32'd0);

    // Back-to-back load of slot 1.
    load_start = 1'b1;
    load_prog  = 2'd1;
    tick;
    load_start = 1'b0;
    chk("s1_ready", 32'(load_ready), 32'd1);
    chk("s1_busy",  32'(load_busy),  32'd1);
    chk("s1_done0", 32'(load_done),  32'd0);
    for (int i = 0; i < PW; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h1000_0000 + i;
      tick;
      if (i == PW - 2) chk("s1_done_early", 32'(load_done), 32'd0);
    end
    load_valid = 1'b0;
    chk("s1_done",       32'(load_done),  32'd1);
    chk("s1_done_ready", 32'(load_ready), 32'd0);
    chk("s1_done_busy",  32'(load_busy),  32'd1);
    fetch(1, 5);
    tick;
    chk("s1_done_pulse", 32'(load_done),   32'd0);
    chk("s1_idle_busy",  32'(load_busy),   32'd0);
    chk("s1_f5_valid",   32'(fetch_valid), 32'd1);
    chk("s1_f5_instr",   instrucao,        32'h1000_0005);
    chk("s1_f5_fault",   32'(fetch_fault), 32'd0);
    fetch_req = 1'b0;
    tick;
    chk("hold_valid", 32'(fetch_valid), 32'd0);
    chk("hold_fault", 32'(fetch_fault), 32'd0);
    chk("hold_instr", instrucao,        32'h1000_0005);

    // Address boundary on a loaded slot.
    fetch(1, PW);
    tick;
    chk("oor_instr", instrucao,        32'd0);
    chk("oor_fault", 32'(fetch_fault), 32'd1);
    fetch(1, PW - 1);
    tick;
    chk("last_instr", instrucao,        32'h1000_001f);
    chk("last_fault", 32'(fetch_fault), 32'd0);

    // Slot 2 loaded with gapped valid while fetches alternate slot 1 / slot 2.
    fetch_req  = 1'b0;
    load_start = 1'b1;
    load_prog  = 2'd2;
    tick;
    load_start = 1'b0;
    words = 0;
    for (int k = 0; k < 70; k++) begin
      load_valid = (k % 2 == 0) && (words < PW);
      load_data  = 32'h2000_0000 + words;
      fetch_req  = 1'b1;
      fetch_addr = AW'(k % PW);
      if (k % 2 == 0) begin
        prog_sel = 2'd1;
        e_instr  = 32'h1000_0000 + (k % PW);
        e_fault  = 1'b0;
      end else if (words == PW) begin
        prog_sel = 2'd2;
        e_instr  = 32'h2000_0000 + (k % PW);
        e_fault  = 1'b0;
      end else begin
        prog_sel = 2'd2;
        e_instr  = 32'd0;
        e_fault  = 1'b1;
      end
      acc = load_valid;
      tick;
      if (acc) words++;
      e_done = acc && (words == PW);
      chk("mix_instr", instrucao,        e_instr);
      chk("mix_fault", 32'(fetch_fault), 32'(e_fault));
      chk("mix_done",  32'(load_done),   32'(e_done));
    end
    fetch_req  = 1'b0;
    load_valid = 1'b0;
    tick;

    // Reset in the middle of a slot-3 load.
    load_start = 1'b1;
    load_prog  = 2'd3;
    tick;
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h3fff_0000 + i;
      tick;
    end
    reset_n = 1'b0;
    tick;
    chk("mrst_valid", 32'(fetch_valid), 32'd0);
    chk("mrst_instr", instrucao,        32'd0);
    chk("mrst_fault", 32'(fetch_fault), 32'd0);
    chk("mrst_ready", 32'(load_ready),  32'd0);
    chk("mrst_busy",  32'(load_busy),   32'd0);
    chk("mrst_done",  32'(load_done),   32'd0);
    reset_n    = 1'b1;
    load_valid = 1'b0;
    load_start = 1'b1;
    load_prog  = 2'd3;
    fetch(3, 0);
    tick;
    load_start = 1'b0;
    chk("post_s3_valid", 32'(fetch_valid), 32'd1);
    chk("post_s3_fault", 32'(fetch_fault), 32'd1);
    chk("post_s3_instr", instrucao,        32'd0);
    chk("post_busy",     32'(load_busy),   32'd1);
    chk("post_ready",    32'(load_ready),  32'd1);
    fetch(1, 0);
    tick;
    chk("post_s1_fault", 32'(fetch_fault), 32'd1);
    chk("post_s1_instr", instrucao,        32'd0);
    fetch_req = 1'b0;

    // Complete slot 3 while a conflicting load_start for slot 0 is issued.
    for (int i = 0; i < PW; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h3000_0000 + i;
      load_start = (i == 5);
      load_prog  = 2'd0;
      tick;
    end
    load_start = 1'b0;
    load_valid = 1'b0;
    chk("s3_done", 32'(load_done), 32'd1);
    fetch(3, 7);
    tick;
    chk("s3_f7_instr", instrucao,        32'h3000_0007);
    chk("s3_f7_fault", 32'(fetch_fault), 32'd0);
    chk("s3_idle",     32'(load_busy),   32'd0);
    fetch(0, 0);
    tick;
    chk("s0_ignored_fault", 32'(fetch_fault), 32'd1);
    chk("s0_ignored_busy",  32'(load_busy),   32'd0);
    fetch(2, 3);
    tick;
    chk("s2_cleared_fault", 32'(fetch_fault), 32'd1);
    chk("s2_cleared_instr", instrucao,        32'd0);
    fetch(3, PW - 1);
    tick;
    chk("s3_last_instr", instrucao,        32'h3000_001f);
    chk("s3_last_fault", 32'(fetch_fault), 32'd0);
    fetch_req = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
